// File: rtl/alu_pkg.sv
// ALU execute-stage package: opcode encoding shared by the stage, the core and the bench.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_e;

    localparam int ALU_OP_WIDTH = 3;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: computes the result of one opcode and flags a zero result.
import alu_pkg::*;

module alu_core #(
    parameter int DATA_WIDTH = 32
) (
    input  alu_op_e               op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o
);

    localparam int ShiftWidth = $clog2(DATA_WIDTH);

    logic [ShiftWidth-1:0] shAmt;
    logic                  lessThan;

    assign shAmt    = b_i[ShiftWidth-1:0];
    assign lessThan = $signed(a_i) < $signed(b_i);

    // Select the operation result; shifts only look at the low bits of operand B.
    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_SLL: result_o = a_i << shAmt;
            ALU_SRL: result_o = a_i >> shAmt;
            ALU_SLT: result_o = {{(DATA_WIDTH-1){1'b0}}, lessThan};
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Single-cycle ALU execute stage with register-file read/write ports.
// Optional build macro ALU_FWD_EN: forward the EX result on a read-after-write
// hazard instead of stalling the incoming instruction for one cycle.
import alu_pkg::*;

module alu_exec_stage #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  alu_op_e               instr_op_i,
    input  logic [ADDR_WIDTH-1:0] instr_rs1_i,
    input  logic [ADDR_WIDTH-1:0] instr_rs2_i,
    input  logic [ADDR_WIDTH-1:0] instr_rd_i,
    output logic [ADDR_WIDTH-1:0] raddr_a_o,
    input  logic [DATA_WIDTH-1:0] rdata_a_i,
    output logic [ADDR_WIDTH-1:0] raddr_b_o,
    input  logic [DATA_WIDTH-1:0] rdata_b_i,
    output logic [ADDR_WIDTH-1:0] waddr_c_o,
    output logic [DATA_WIDTH-1:0] wdata_c_o,
    output logic                  we_c_o,
    output logic                  res_valid_o,
    output logic                  res_zero_o,
    output logic [15:0]           retired_cnt_o
);

    logic                  exValid_q, exValid_d;
    alu_op_e               exOp_q, exOp_d;
    logic [DATA_WIDTH-1:0] exA_q, exA_d;
    logic [DATA_WIDTH-1:0] exB_q, exB_d;
    logic [ADDR_WIDTH-1:0] exRd_q, exRd_d;
    logic [15:0]           retiredCnt_q, retiredCnt_d;

    logic [DATA_WIDTH-1:0] exResult;
    logic                  exZero;
    logic                  rs1Match;
    logic                  rs2Match;
    logic                  accept;
    logic [DATA_WIDTH-1:0] operandA;
    logic [DATA_WIDTH-1:0] operandB;

    assign raddr_a_o = instr_rs1_i;
    assign raddr_b_o = instr_rs2_i;

    assign rs1Match = exValid_q && (instr_rs1_i == exRd_q);
    assign rs2Match = exValid_q && (instr_rs2_i == exRd_q);

`ifdef ALU_FWD_EN
    assign operandA      = rs1Match ? exResult : rdata_a_i;
    assign operandB      = rs2Match ? exResult : rdata_b_i;
    assign instr_ready_o = 1'b1;
`else
    logic hazard;
    assign hazard        = instr_valid_i && (rs1Match || rs2Match);
    assign operandA      = rdata_a_i;
    assign operandB      = rdata_b_i;
    assign instr_ready_o = ~hazard;
`endif

    assign accept = instr_valid_i && instr_ready_o;

    alu_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu_core (
        .op_i     (exOp_q),
        .a_i      (exA_q),
        .b_i      (exB_q),
        .result_o (exResult),
        .zero_o   (exZero)
    );

    // Next-state for the EX register and retire counter; EX fields only change on accept so the write port holds.
    always_comb begin
        exValid_d    = accept;
        exOp_d       = exOp_q;
        exA_d        = exA_q;
        exB_d        = exB_q;
        exRd_d       = exRd_q;
        retiredCnt_d = retiredCnt_q;
        if (accept) begin
            exOp_d = instr_op_i;
            exA_d  = operandA;
            exB_d  = operandB;
            exRd_d = instr_rd_i;
        end
        if (exValid_q) begin
            retiredCnt_d = retiredCnt_q + 16'd1;
        end
    end

    // EX pipeline register and counter; reset drops any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exValid_q    <= 1'b0;
            exOp_q       <= ALU_ADD;
            exA_q        <= '0;
            exB_q        <= '0;
            exRd_q       <= '0;
            retiredCnt_q <= '0;
        end else begin
            exValid_q    <= exValid_d;
            exOp_q       <= exOp_d;
            exA_q        <= exA_d;
            exB_q        <= exB_d;
            exRd_q       <= exRd_d;
            retiredCnt_q <= retiredCnt_d;
        end
    end

    assign we_c_o        = exValid_q;
    assign res_valid_o   = exValid_q;
    assign res_zero_o    = exValid_q && exZero;
    assign waddr_c_o     = exRd_q;
    assign wdata_c_o     = exResult;
    assign retired_cnt_o = retiredCnt_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage paired with a behavioural 2R1W register file.
import alu_pkg::*;

module tb_alu_exec_stage;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_valid_i;
    logic          instr_ready_o;
    alu_op_e       instr_op_i;
    logic [AW-1:0] instr_rs1_i;
    logic [AW-1:0] instr_rs2_i;
    logic [AW-1:0] instr_rd_i;
    logic [AW-1:0] raddr_a_o;
    logic [DW-1:0] rdata_a_i;
    logic [AW-1:0] raddr_b_o;
    logic [DW-1:0] rdata_b_i;
    logic [AW-1:0] waddr_c_o;
    logic [DW-1:0] wdata_c_o;
    logic          we_c_o;
    logic          res_valid_o;
    logic          res_zero_o;
    logic [15:0]   retired_cnt_o;

    logic          tbWe;
    logic [AW-1:0] tbWaddr;
    logic [DW-1:0] tbWdata;
    logic [DW-1:0] rf [2**AW];

    int passCount  = 0;
    int checkCount = 0;
    int expRetired = 0;

    typedef struct {
        alu_op_e       op;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] expData;
        logic          expZero;
    } vec_t;

    vec_t vecs [11];

    alu_exec_stage #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .instr_op_i    (instr_op_i),
        .instr_rs1_i   (instr_rs1_i),
        .instr_rs2_i   (instr_rs2_i),
        .instr_rd_i    (instr_rd_i),
        .raddr_a_o     (raddr_a_o),
        .rdata_a_i     (rdata_a_i),
        .raddr_b_o     (raddr_b_o),
        .rdata_b_i     (rdata_b_i),
        .waddr_c_o     (waddr_c_o),
        .wdata_c_o     (wdata_c_o),
        .we_c_o        (we_c_o),
        .res_valid_o   (res_valid_o),
        .res_zero_o    (res_zero_o),
        .retired_cnt_o (retired_cnt_o)
    );

    always #5 clk = ~clk;

    // Register file: DUT write port has priority over the bench preload port.
    always_ff @(posedge clk) begin
        if (we_c_o) begin
            rf[waddr_c_o] <= wdata_c_o;
        end else if (tbWe) begin
            rf[tbWaddr] <= tbWdata;
        end
    end

    assign rdata_a_i = rf[raddr_a_o];
    assign rdata_b_i = rf[raddr_b_o];

    // Hard stop if the run somehow stalls.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Preload one register while the EX stage is idle; starts and ends on a falling edge.
    task automatic setReg(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        tbWe    = 1'b1;
        tbWaddr = addr;
        tbWdata = data;
        @(negedge clk);
        tbWe    = 1'b0;
    endtask

    // Offer one instruction, hold it until accepted, return on the falling edge of its EX cycle.
    task automatic applyStimulus(input alu_op_e op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                 input logic [AW-1:0] rd, output int stalls);
        bit accepted;
        stalls        = 0;
        accepted      = 1'b0;
        instr_op_i    = op;
        instr_rs1_i   = rs1;
        instr_rs2_i   = rs2;
        instr_rd_i    = rd;
        instr_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (instr_ready_o) begin
                accepted = 1'b1;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        @(negedge clk);
        instr_valid_i = 1'b0;
        if (!accepted) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic checkResult(input string name, input logic [AW-1:0] rd, input logic [DW-1:0] expData,
                               input logic expZero);
        checkOutput({name, "_we"}, {31'd0, we_c_o}, 32'd1);
        checkOutput({name, "_valid"}, {31'd0, res_valid_o}, 32'd1);
        checkOutput({name, "_waddr"}, {27'd0, waddr_c_o}, {27'd0, rd});
        checkOutput({name, "_wdata"}, wdata_c_o, expData);
        checkOutput({name, "_zero"}, {31'd0, res_zero_o}, {31'd0, expZero});
    endtask

    // One cycle after a result: write strobes drop, write port holds, RF and counter updated.
    task automatic checkIdle(input string name, input logic [AW-1:0] rd, input logic [DW-1:0] expData);
        @(negedge clk);
        expRetired++;
        checkOutput({name, "_idle_we"}, {31'd0, we_c_o}, 32'd0);
        checkOutput({name, "_idle_valid"}, {31'd0, res_valid_o}, 32'd0);
        checkOutput({name, "_idle_zero"}, {31'd0, res_zero_o}, 32'd0);
        checkOutput({name, "_hold_waddr"}, {27'd0, waddr_c_o}, {27'd0, rd});
        checkOutput({name, "_hold_wdata"}, wdata_c_o, expData);
        checkOutput({name, "_rf"}, rf[rd], expData);
        checkOutput({name, "_retired"}, {16'd0, retired_cnt_o}, expRetired[31:0] & 32'hFFFF);
    endtask

    initial begin
        int stalls;
        int expStalls;

        vecs[0]  = '{ALU_ADD, 5'd1, 5'd2, 5'd3,  32'd5,        32'd7,        32'd12,       1'b0};
        vecs[1]  = '{ALU_SUB, 5'd1, 5'd2, 5'd4,  32'd0,        32'd1,        32'hFFFFFFFF, 1'b0};
        vecs[2]  = '{ALU_XOR, 5'd1, 5'd1, 5'd5,  32'h00001234, 32'h00001234, 32'd0,        1'b1};
        vecs[3]  = '{ALU_SLT, 5'd1, 5'd2, 5'd7,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
        vecs[4]  = '{ALU_SLL, 5'd1, 5'd2, 5'd8,  32'd1,        32'd33,       32'd2,        1'b0};
        vecs[5]  = '{ALU_SRL, 5'd1, 5'd2, 5'd11, 32'h80000000, 32'd31,       32'd1,        1'b0};
        vecs[6]  = '{ALU_AND, 5'd1, 5'd2, 5'd12, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0};
        vecs[7]  = '{ALU_OR,  5'd1, 5'd2, 5'd13, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0};
        vecs[8]  = '{ALU_SLT, 5'd1, 5'd2, 5'd14, 32'd5,        32'd3,        32'd0,        1'b1};
        vecs[9]  = '{ALU_ADD, 5'd1, 5'd2, 5'd15, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
        vecs[10] = '{ALU_SLT, 5'd1, 5'd2, 5'd16, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1};

        rst_n         = 1'b0;
        instr_valid_i = 1'b0;
        instr_op_i    = ALU_ADD;
        instr_rs1_i   = '0;
        instr_rs2_i   = '0;
        instr_rd_i    = '0;
        tbWe          = 1'b0;
        tbWaddr       = '0;
        tbWdata       = '0;

        $display("[TB] reset phase");
        repeat (3) @(negedge clk);
        checkOutput("rst_we", {31'd0, we_c_o}, 32'd0);
        checkOutput("rst_valid", {31'd0, res_valid_o}, 32'd0);
        checkOutput("rst_zero", {31'd0, res_zero_o}, 32'd0);
        checkOutput("rst_waddr", {27'd0, waddr_c_o}, 32'd0);
        checkOutput("rst_wdata", wdata_c_o, 32'd0);
        checkOutput("rst_retired", {16'd0, retired_cnt_o}, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_rst", {31'd0, instr_ready_o}, 32'd1);
        instr_rs1_i = 5'd9;
        instr_rs2_i = 5'd17;
        #1;
        checkOutput("raddr_a", {27'd0, raddr_a_o}, 32'd9);
        checkOutput("raddr_b", {27'd0, raddr_b_o}, 32'd17);
        @(negedge clk);

        $display("[TB] vector table");
        foreach (vecs[i]) begin
            setReg(vecs[i].rs1, vecs[i].a);
            if (vecs[i].rs2 != vecs[i].rs1) begin
                setReg(vecs[i].rs2, vecs[i].b);
            end
            applyStimulus(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, stalls);
            checkOutput($sformatf("v%0d_stalls", i), stalls, 32'd0);
            checkResult($sformatf("v%0d", i), vecs[i].rd, vecs[i].expData, vecs[i].expZero);
            checkIdle($sformatf("v%0d", i), vecs[i].rd, vecs[i].expData);
        end

        $display("[TB] back-to-back dependency");
`ifdef ALU_FWD_EN
        expStalls = 0;
`else
        expStalls = 1;
`endif
        setReg(5'd1, 32'd5);
        setReg(5'd2, 32'd7);
        setReg(5'd3, 32'd0);
        applyStimulus(ALU_ADD, 5'd1, 5'd2, 5'd3, stalls);
        checkOutput("b2b_first_stalls", stalls, 32'd0);
        checkResult("b2b_first", 5'd3, 32'd12, 1'b0);
        expRetired++;
        applyStimulus(ALU_ADD, 5'd3, 5'd3, 5'd6, stalls);
        checkOutput("b2b_second_stalls", stalls, expStalls);
        checkResult("b2b_second", 5'd6, 32'd24, 1'b0);
        checkIdle("b2b_second", 5'd6, 32'd24);

        $display("[TB] reset during EX cycle");
        setReg(5'd9, 32'hDEADBEEF);
        setReg(5'd1, 32'd5);
        setReg(5'd2, 32'd7);
        applyStimulus(ALU_ADD, 5'd1, 5'd2, 5'd9, stalls);
        checkOutput("midrst_we_before", {31'd0, we_c_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_we", {31'd0, we_c_o}, 32'd0);
        checkOutput("midrst_wdata", wdata_c_o, 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        expRetired = 0;
        #1;
        checkOutput("midrst_rf", rf[9], 32'hDEADBEEF);
        checkOutput("midrst_retired", {16'd0, retired_cnt_o}, 32'd0);
        checkOutput("midrst_ready", {31'd0, instr_ready_o}, 32'd1);
        @(negedge clk);
        applyStimulus(ALU_ADD, 5'd1, 5'd2, 5'd4, stalls);
        checkOutput("postrst_stalls", stalls, 32'd0);
        checkResult("postrst", 5'd4, 32'd12, 1'b0);
        checkIdle("postrst", 5'd4, 32'd12);

        $display("[TB] retire counter wrap");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        expRetired = 0;
        @(negedge clk);
        instr_op_i    = ALU_ADD;
        instr_rs1_i   = 5'd1;
        instr_rs2_i   = 5'd2;
        instr_rd_i    = 5'd10;
        instr_valid_i = 1'b1;
        repeat (65535) @(negedge clk);
        instr_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("wrap_ffff", {16'd0, retired_cnt_o}, 32'h0000FFFF);
        applyStimulus(ALU_ADD, 5'd1, 5'd2, 5'd10, stalls);
        checkOutput("wrap_last_we", {31'd0, we_c_o}, 32'd1);
        @(negedge clk);
        checkOutput("wrap_zero", {16'd0, retired_cnt_o}, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
